// File: rtl/doa_pkg.sv
// doa_pkg: widths shared along the correlation -> DOA chain, plus the result-register state type.
package doa_pkg;
    localparam int CORR_IN_W = 25;
    localparam int CORR_FRAME_LEN = 128;
    localparam int CORR_ACC_W = CORR_IN_W + $clog2(CORR_FRAME_LEN);
    localparam int CORR_CNT_W = $clog2(CORR_FRAME_LEN) + 1;
    typedef enum logic {EMPTY, FULL} out_state_e;
endpackage

// File: rtl/corr_frame_accum_if.sv
// corr_frame_accum_if: per-sample product stream in, per-frame covariance result out.
interface corr_frame_accum_if import doa_pkg::*; #(
    parameter int IN_W = CORR_IN_W,
    parameter int ACC_W = CORR_ACC_W,
    parameter int CNT_W = CORR_CNT_W
);
    logic signed [IN_W-1:0] i_r, i_c;
    logic i_valid, i_last, o_ready;
    logic signed [ACC_W-1:0] o_acc_r, o_acc_c;
    logic [CNT_W-1:0] o_count;
    logic o_len_err, o_valid, i_ready;
    modport slave (
        input i_r, i_c, i_valid, i_last, i_ready,
        output o_ready, o_acc_r, o_acc_c, o_count, o_len_err, o_valid
    );
    modport master (
        output i_r, i_c, i_valid, i_last, i_ready,
        input o_ready, o_acc_r, o_acc_c, o_count, o_len_err, o_valid
    );
endinterface

// File: rtl/corr_frame_accum_acc_lane.sv
// corr_acc_lane: one signed accumulate/clear lane with a result register loaded on the last beat.
// CORR_AVG_SHIFT_EN: result becomes the sum divided by FRAME_LEN, rounded half-up.
module corr_acc_lane #(
    parameter int IN_W = 25,
    parameter int ACC_W = 32,
    parameter int S = 7
) (
    input logic clk,
    input logic rst,
    input logic en_i,
    input logic last_i,
    input logic signed [IN_W-1:0] din_i,
    output logic signed [ACC_W-1:0] res_o
);
`ifdef CORR_AVG_SHIFT_EN
    localparam int SH = S;
`else
    localparam int SH = 0;
`endif
    // With SH = 0 the rounding constant is zero, leaving the raw sum.
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'((2 ** SH) / 2);
    logic signed [ACC_W-1:0] acc_q, acc_d, res_q, res_d, sum;
    assign sum = acc_q + ACC_W'(din_i);
    always_comb begin
        acc_d = en_i ? (last_i ? '0 : sum) : acc_q;
        res_d = en_i && last_i ? (sum + HALF) >>> SH : res_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end
    assign res_o = res_q;
endmodule

// File: rtl/corr_frame_accum.sv
// corr_frame_accum: sums complex correlation products over a last-delimited frame, one result per frame.
// CORR_AVG_SHIFT_EN (in the lanes): report the rounded per-sample average instead of the raw sum.
module corr_frame_accum import doa_pkg::*; #(
    parameter int IN_W = CORR_IN_W,
    parameter int FRAME_LEN = CORR_FRAME_LEN,
    parameter int ACC_W = IN_W + $clog2(FRAME_LEN),
    parameter int CNT_W = $clog2(FRAME_LEN) + 1
) (
    input logic i_clk,
    input logic i_reset,
    corr_frame_accum_if.slave s
);
    out_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d, cnt_inc;
    logic len_err_q, len_err_d, take, load;
    // A held result only stalls input when downstream is not draining it this cycle.
    assign s.o_ready = state_q == EMPTY || s.i_ready;
    assign take = s.i_valid && s.o_ready;
    assign load = take && s.i_last;
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    always_comb begin
        state_d = load ? FULL : s.i_ready ? EMPTY : state_q;
        cnt_d = load ? '0 : take ? cnt_inc : cnt_q;
        count_d = load ? cnt_inc : count_q;
        len_err_d = load ? cnt_inc != CNT_W'(FRAME_LEN) : len_err_q;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= EMPTY;
            cnt_q <= '0;
            count_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            count_q <= count_d;
            len_err_q <= len_err_d;
        end
    end
    assign s.o_valid = state_q == FULL;
    assign s.o_count = count_q;
    assign s.o_len_err = len_err_q;
    corr_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .S($clog2(FRAME_LEN))) u_lane_r (
        .clk(i_clk), .rst(i_reset), .en_i(take), .last_i(s.i_last), .din_i(s.i_r), .res_o(s.o_acc_r)
    );
    corr_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .S($clog2(FRAME_LEN))) u_lane_c (
        .clk(i_clk), .rst(i_reset), .en_i(take), .last_i(s.i_last), .din_i(s.i_c), .res_o(s.o_acc_c)
    );
endmodule

// File: tb/tb_corr_frame_accum.sv
// tb_corr_frame_accum: randomized frames against a plain-arithmetic frame-sum model, scoreboard-checked.
module tb_corr_frame_accum;
    import doa_pkg::*;
    localparam int IN_W = CORR_IN_W;
    localparam int ACC_W = CORR_ACC_W;
    localparam int CNT_W = CORR_CNT_W;
    localparam int FL = CORR_FRAME_LEN;
    localparam int MAXV = 2 ** (IN_W - 1) - 1;
    localparam int MINV = -(2 ** (IN_W - 1));
    typedef struct {longint r; longint c; longint cnt; longint err;} exp_t;
    logic clk = 0, rst = 1;
    int checks = 0, errors = 0, rdy_mode = 0, nb = 0;
    longint sum_r = 0, sum_c = 0;
    exp_t q[$];
    corr_frame_accum_if ifc();
    corr_frame_accum dut (.i_clk(clk), .i_reset(rst), .s(ifc));
    always #5 clk = ~clk;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic longint res_of(longint s);
        longint w = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
`ifdef CORR_AVG_SHIFT_EN
        longint d = w + FL / 2;
        w = d / FL;
        if (d % FL != 0 && d < 0) w = w - 1;
`endif
        return w;
    endfunction

    function automatic void model(int r, int c, bit last);
        exp_t e;
        sum_r += r;
        sum_c += c;
        nb++;
        if (last) begin
            e.r = res_of(sum_r);
            e.c = res_of(sum_c);
            e.cnt = nb > 2 ** CNT_W - 1 ? 2 ** CNT_W - 1 : nb;
            e.err = nb != FL ? 1 : 0;
            q.push_back(e);
            sum_r = 0;
            sum_c = 0;
            nb = 0;
        end
    endfunction

    always @(posedge clk) begin
        #1;
        ifc.i_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : $urandom_range(0, 3) != 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifc.o_valid && ifc.i_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result %0d with no frame expected", ifc.o_acc_r);
            end else begin
                e = q.pop_front();
                chk("acc_r", longint'(ifc.o_acc_r), e.r);
                chk("acc_c", longint'(ifc.o_acc_c), e.c);
                chk("count", longint'(ifc.o_count), e.cnt);
                chk("len_err", longint'(ifc.o_len_err), e.err);
            end
        end
    end

    task automatic beat(input int r, input int c, input bit last);
        int n = 0;
        ifc.i_r = IN_W'(r);
        ifc.i_c = IN_W'(c);
        ifc.i_last = last;
        ifc.i_valid = 1'b1;
        @(negedge clk);
        while (!ifc.o_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL o_ready_timeout: got 0 for %0d cycles expected 1", n);
        end
        @(posedge clk);
        #1;
        model(r, c, last);
        ifc.i_valid = 1'b0;
    endtask

    task automatic frame(input int len, input int fr, input int fc, input bit rnd);
        for (int i = 1; i <= len; i++) begin
            int r = rnd ? int'($urandom_range(0, 2 ** IN_W - 1)) + MINV : fr;
            int c = rnd ? int'($urandom_range(0, 2 ** IN_W - 1)) + MINV : fc;
            beat(r, c, i == len);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        rdy_mode = 0;
        while (q.size() != 0 && n < 1000) begin
            n++;
            @(posedge clk);
        end
        #1;
        chk("drain_queue", q.size(), 0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_valid"}, longint'(ifc.o_valid), 0);
        chk({tag, "_acc_r"}, longint'(ifc.o_acc_r), 0);
        chk({tag, "_acc_c"}, longint'(ifc.o_acc_c), 0);
        chk({tag, "_count"}, longint'(ifc.o_count), 0);
        chk({tag, "_len_err"}, longint'(ifc.o_len_err), 0);
    endtask

    initial begin
        ifc.i_valid = 0;
        ifc.i_last = 0;
        ifc.i_r = '0;
        ifc.i_c = '0;
        #1;
        chk_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        frame(FL, 1, -1, 0);
        frame(FL, MAXV, MINV, 0);
        frame(FL, 0, 0, 1);
        frame(FL, 0, 0, 1);
        for (int i = 1; i <= 5; i++) beat(i, -i, i == 5);
        frame(1, 7, -9, 0);
        wait_drain();
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        beat(3, 4, 1);
        chk("stall_queue", q.size(), 1);
        ifc.i_r = IN_W'(5);
        ifc.i_c = IN_W'(6);
        ifc.i_last = 0;
        ifc.i_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_o_ready", longint'(ifc.o_ready), 0);
            chk("stall_o_valid", longint'(ifc.o_valid), 1);
            chk("stall_acc_r", longint'(ifc.o_acc_r), q[0].r);
            chk("stall_count", longint'(ifc.o_count), q[0].cnt);
        end
        rdy_mode = 0;
        beat(5, 6, 0);
        frame(FL - 1, 0, 0, 1);
        wait_drain();
        for (int i = 0; i < 59; i++) beat(int'($urandom_range(0, 1000)), -3, 0);
        rst = 1;
        #1;
        chk_zero("midframe_reset");
        ifc.i_valid = 0;
        sum_r = 0;
        sum_c = 0;
        nb = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        frame(FL, 0, 0, 1);
        rdy_mode = 1;
        for (int f = 0; f < 12; f++) begin
            int pick = int'($urandom_range(0, 5));
            int len = pick == 0 ? 1 : pick == 1 ? FL - 1 : pick == 2 ? FL + 1 : pick == 3 ? FL : int'($urandom_range(2, 140));
            frame(len, 0, 0, 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        frame(300, 1, 2, 0);
        wait_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
